// File: rtl/shift_unit_seq.sv
// Iterative SLL/SRL/SRA unit: one bit position per clock, for shift instructions in EX.
// Latency: shamt+1 cycles from the accepted start (1 cycle for shamt=0 or the reserved op).
// Backpressure: no handshake; start_i is ignored while busy_o is high, so the pipeline must stall.
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [SHW-1:0]   shamt_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;

  // Next-state logic: load on an accepted start, shift one bit per cycle, pulse done.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          acc_d = data_i;
          op_d  = op_i;
          // Reserved op is a pass-through, so it runs with a zero count.
          cnt_d = (op_i == OP_RSV) ? '0 : shamt_i;
          state_d = (cnt_d == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        case (op_q)
          OP_SLL:  acc_d = {acc_q[WIDTH-2:0], 1'b0};
          OP_SRL:  acc_d = {1'b0, acc_q[WIDTH-1:1]};
          OP_SRA:  acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
          default: acc_d = acc_q;
        endcase
        cnt_d = cnt_q - SHW'(1);
        // Leave on the edge where the count reaches zero.
        if (cnt_q == SHW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset that overrides any start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Result is the working register; it holds from DONE until the next accepted start.
  assign result_o = acc_q;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: behavioural latency/result model plus directed vectors.
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] data = 32'd0;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  shift_unit_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .op_i     (op),
    .shamt_i  (shamt),
    .data_i   (data),
    .result_o (result),
    .busy_o   (busy),
    .done_o   (done)
  );

  always #5 clk = ~clk;

  // Reference shift with plain operators.
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
    case (o)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  // Model: busy flag, cycles left until done, expected final result.
  logic        m_init = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_res  = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_left = 0;
      m_res  = 32'd0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_res  = ref_shift(op, shamt, data);
        m_left = (op == 2'b11) ? 0 : int'(shamt);
        m_done = (m_left == 0);
      end
    end else if (m_done) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) m_done = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
      if (!m_busy || m_done) chk("model_result", result, m_res);
    end
  end

  // One operation with a single-cycle start; checks literal latency, result and busy length.
  task automatic run_op(input string name, input logic [1:0] o, input logic [4:0] s,
                        input logic [31:0] d, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; data = d;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0; op = 2'b11; shamt = 5'h1f; data = 32'hDEADBEEF;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_result"}, result, exp_res);
    chk({name, "_busy_cycles"}, busy_cnt, exp_lat);
    @(negedge clk);
    chk({name, "_busy_fall"}, {31'd0, busy}, 32'd0);
    chk({name, "_result_held"}, result, exp_res);
  endtask

  initial begin
    int ndone;
    int first_k;
    int last_k;
    logic saw_done;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;

    // Model sanity pins.
    chk("ref_sra31", ref_shift(2'b10, 5'd31, 32'h80000000), 32'hFFFFFFFF);
    chk("ref_srl31", ref_shift(2'b01, 5'd31, 32'h80000000), 32'h00000001);

    run_op("sll4", 2'b00, 5'd4, 32'h00000001, 32'h00000010, 5);
    run_op("sra31", 2'b10, 5'd31, 32'h80000000, 32'hFFFFFFFF, 32);
    run_op("srl31", 2'b01, 5'd31, 32'h80000000, 32'h00000001, 32);
    run_op("zero_cnt", 2'b00, 5'd0, 32'h12345678, 32'h12345678, 1);
    run_op("rsv_op", 2'b11, 5'd7, 32'h12345678, 32'h12345678, 1);
    run_op("sra_pos", 2'b10, 5'd3, 32'h40000000, 32'h08000000, 4);

    // Reset in the 5th SHIFT cycle of a long SLL.
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd20; data = 32'hFFFFFFFF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("rst_mid_no_done", {31'd0, saw_done}, 32'd0);

    // Start pulse during SHIFT is ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b01; shamt = 5'd8; data = 32'hF0000000;
    ndone = 0;
    first_k = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 2) begin
        start = 1'b1; op = 2'b00; shamt = 5'd1; data = 32'h00000005;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first_k == 0) first_k = k;
        chk("ignore_result", result, 32'h00F00000);
      end
    end
    chk("ignore_latency", first_k, 9);
    chk("ignore_done_count", ndone, 1);
    run_op("after_ignore", 2'b01, 5'd4, 32'h000000F0, 32'h0000000F, 5);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd2; data = 32'h00000003;
    ndone = 0;
    first_k = 0;
    last_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("b2b_result", result, 32'h0000000C);
        if (first_k == 0) first_k = k;
        else chk("b2b_spacing", k - last_k, 4);
        last_k = k;
      end
    end
    start = 1'b0;
    chk("b2b_first", first_k, 3);
    chk("b2b_count", ndone, 5);
    repeat (6) @(negedge clk);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
